// File: rtl/vram_sched_pkg.sv
// Shared types and default timing constants for the VRAM access scheduler.
package vram_sched_pkg;

    typedef enum logic [1:0] {ST_INIT, ST_READY, ST_SLOT} sched_state_t;
    typedef enum logic [1:0] {CLI_NONE, CLI_VID, CLI_CPU, CLI_REF} client_t;

    // Per-stage read tag: who asked, and which byte the CPU wants.
    typedef struct packed {
        logic vid;
        logic cpu;
        logic a0;
    } tag_t;

    localparam int SLOT_CYCLES_DEF      = 5;
    localparam int READ_LATENCY_DEF     = 6;
    localparam int REFRESH_INTERVAL_DEF = 405;
    localparam int CPU_MAX_DEFER_DEF    = 2;

endpackage

// File: rtl/vram_refresh_timer.sv
// Free-running refresh interval timer with a sticky pending flag and an
// overrun flag that latches if an interval expires before the previous
// refresh was serviced.
module vram_refresh_timer
    import vram_sched_pkg::*;
#(
    parameter int INTERVAL = REFRESH_INTERVAL_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    output logic o_pending,
    output logic o_overrun
);

    localparam int TW = $clog2(INTERVAL);

    logic [TW-1:0] r_cnt;
    logic          r_pending;
    logic          r_overrun;
    logic          w_expire;

    assign w_expire  = (r_cnt == '0);
    assign o_pending = r_pending;
    assign o_overrun = r_overrun;

    // Count down, reload on expiry; expiry wins over a same-edge clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt     <= TW'(INTERVAL - 1);
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_expire) begin
                r_cnt <= TW'(INTERVAL - 1);
            end else begin
                r_cnt <= r_cnt - TW'(1);
            end
            if (w_expire) begin
                r_pending <= 1'b1;
            end else if (i_clear) begin
                r_pending <= 1'b0;
            end
            if (w_expire && r_pending && !i_clear) begin
                r_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/vram_access_scheduler.sv
// Requesting side of the SDRAM controller: arbitrates refresh, CPU and video,
// paces commands to the fixed service slot and routes read data back by tag.
//
// Handshake: a client holds req until it sees its one-cycle ack; ack is
// registered on the issue edge, and req still high on the edge after ack is
// treated as a fresh request. valid pulses carry no back-pressure.
module vram_access_scheduler
    import vram_sched_pkg::*;
#(
    parameter int SLOT_CYCLES      = SLOT_CYCLES_DEF,
    parameter int READ_LATENCY     = READ_LATENCY_DEF,
    parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEF,
    parameter int CPU_MAX_DEFER    = CPU_MAX_DEFER_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mem_enabled,
    input  logic         vid_req,
    input  logic [22:0]  vid_addr,
    output logic         vid_ack,
    output logic [15:0]  vid_data,
    output logic         vid_valid,
    input  logic         cpu_req,
    input  logic         cpu_wr,
    input  logic [22:0]  cpu_addr,
    input  logic [7:0]   cpu_din,
    output logic         cpu_ack,
    output logic [7:0]   cpu_dout,
    output logic         cpu_valid,
    output logic         mem_read,
    output logic         mem_write,
    output logic         mem_refresh,
    output logic [22:0]  mem_addr,
    output logic [7:0]   mem_din8,
    input  logic [15:0]  mem_dout16,
    output sched_state_t dbg_state,
    output logic         dbg_refresh_overrun
);

    localparam int SW = $clog2(SLOT_CYCLES + 1);
    localparam int DW = $clog2(CPU_MAX_DEFER + 1);

    sched_state_t  r_state;
    sched_state_t  w_state_nxt;
    client_t       w_grant;
    logic [SW-1:0] r_slot_cnt;
    logic [DW-1:0] r_defer_cnt;
    logic          w_ref_pending;
    logic          w_cpu_forced;
    tag_t          w_tag_in;
    tag_t          r_tag [READ_LATENCY];

    assign dbg_state    = r_state;
    assign w_cpu_forced = cpu_req && (r_defer_cnt == DW'(CPU_MAX_DEFER));

    vram_refresh_timer #(
        .INTERVAL (REFRESH_INTERVAL)
    ) u_refresh_timer (
        .i_clk     (clk),
        .i_rst     (reset),
        .i_clear   (w_grant == CLI_REF),
        .o_pending (w_ref_pending),
        .o_overrun (dbg_refresh_overrun)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Arbitration and next-state; a grant only happens in READY.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = CLI_NONE;
        case (r_state)
            ST_INIT: begin
                if (mem_enabled) begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                if (w_ref_pending) begin
                    w_grant = CLI_REF;
                end else if (w_cpu_forced) begin
                    w_grant = CLI_CPU;
                end else if (vid_req) begin
                    w_grant = CLI_VID;
                end else if (cpu_req) begin
                    w_grant = CLI_CPU;
                end
                if (w_grant != CLI_NONE) begin
                    w_state_nxt = ST_SLOT;
                end
            end
            ST_SLOT: begin
                // Returning as the count reaches 0 lets the next issue land
                // exactly SLOT_CYCLES edges after the previous one.
                if (r_slot_cnt == SW'(1)) begin
                    w_state_nxt = ST_READY;
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // Slot pacing counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot_cnt <= '0;
        end else if (w_grant != CLI_NONE) begin
            r_slot_cnt <= SW'(SLOT_CYCLES - 1);
        end else if (r_state == ST_SLOT && r_slot_cnt != '0) begin
            r_slot_cnt <= r_slot_cnt - SW'(1);
        end
    end

    // CPU starvation guard: count video wins while the CPU waits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_defer_cnt <= '0;
        end else if (!cpu_req || w_grant == CLI_CPU) begin
            r_defer_cnt <= '0;
        end else if (w_grant == CLI_VID && r_defer_cnt != DW'(CPU_MAX_DEFER)) begin
            r_defer_cnt <= r_defer_cnt + DW'(1);
        end
    end

    // Issue-edge command pulses, acks and registered address/data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_refresh <= 1'b0;
            vid_ack     <= 1'b0;
            cpu_ack     <= 1'b0;
            mem_addr    <= '0;
            mem_din8    <= '0;
        end else begin
            mem_read    <= (w_grant == CLI_VID) || (w_grant == CLI_CPU && !cpu_wr);
            mem_write   <= (w_grant == CLI_CPU) && cpu_wr;
            mem_refresh <= (w_grant == CLI_REF);
            vid_ack     <= (w_grant == CLI_VID);
            cpu_ack     <= (w_grant == CLI_CPU);
            if (w_grant == CLI_VID) begin
                mem_addr <= vid_addr & 23'h7FFFFE;
            end else if (w_grant == CLI_CPU) begin
                mem_addr <= cpu_addr;
                mem_din8 <= cpu_din;
            end
        end
    end

    assign w_tag_in.vid = (w_grant == CLI_VID);
    assign w_tag_in.cpu = (w_grant == CLI_CPU) && !cpu_wr;
    assign w_tag_in.a0  = (w_grant == CLI_CPU) && !cpu_wr && cpu_addr[0];

    // Tag pipeline: one stage per cycle of read latency, empty when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= w_tag_in;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    // Capture returned data for whichever client owns the exiting tag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vid_valid <= 1'b0;
            vid_data  <= '0;
            cpu_valid <= 1'b0;
            cpu_dout  <= '0;
        end else begin
            vid_valid <= r_tag[READ_LATENCY-1].vid;
            cpu_valid <= r_tag[READ_LATENCY-1].cpu;
            if (r_tag[READ_LATENCY-1].vid) begin
                vid_data <= mem_dout16;
            end
            if (r_tag[READ_LATENCY-1].cpu) begin
                cpu_dout <= r_tag[READ_LATENCY-1].a0 ? mem_dout16[15:8] : mem_dout16[7:0];
            end
        end
    end

endmodule

// File: tb/tb_vram_access_scheduler.sv
// Directed bench for vram_access_scheduler: init gating, read latency and
// routing, CPU write, grant fairness/pacing, refresh cadence, reset abort.
module tb_vram_access_scheduler;
    import vram_sched_pkg::*;

    logic         clk;
    logic         reset;
    logic         mem_enabled;
    logic         vid_req;
    logic [22:0]  vid_addr;
    logic         vid_ack;
    logic [15:0]  vid_data;
    logic         vid_valid;
    logic         cpu_req;
    logic         cpu_wr;
    logic [22:0]  cpu_addr;
    logic [7:0]   cpu_din;
    logic         cpu_ack;
    logic [7:0]   cpu_dout;
    logic         cpu_valid;
    logic         mem_read;
    logic         mem_write;
    logic         mem_refresh;
    logic [22:0]  mem_addr;
    logic [7:0]   mem_din8;
    logic [15:0]  mem_dout16;
    sched_state_t dbg_state;
    logic         dbg_refresh_overrun;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    vram_access_scheduler dut (
        .clk                 (clk),
        .reset               (reset),
        .mem_enabled         (mem_enabled),
        .vid_req             (vid_req),
        .vid_addr            (vid_addr),
        .vid_ack             (vid_ack),
        .vid_data            (vid_data),
        .vid_valid           (vid_valid),
        .cpu_req             (cpu_req),
        .cpu_wr              (cpu_wr),
        .cpu_addr            (cpu_addr),
        .cpu_din             (cpu_din),
        .cpu_ack             (cpu_ack),
        .cpu_dout            (cpu_dout),
        .cpu_valid           (cpu_valid),
        .mem_read            (mem_read),
        .mem_write           (mem_write),
        .mem_refresh         (mem_refresh),
        .mem_addr            (mem_addr),
        .mem_din8            (mem_din8),
        .mem_dout16          (mem_dout16),
        .dbg_state           (dbg_state),
        .dbg_refresh_overrun (dbg_refresh_overrun)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and sample 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int pulses;
        int e0;
        int n;
        int rec_cli [6];
        int rec_cyc [6];
        int exp_cli [6];
        int start;
        int ref_n;
        int last_ref;
        int bad;
        logic found;

        exp_cli = '{1, 1, 2, 1, 1, 2};
        reset = 1'b1; mem_enabled = 1'b0;
        vid_req = 1'b0; vid_addr = '0;
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_din = '0;
        mem_dout16 = '0;
        repeat (3) step();

        // Reset state.
        check("rst_state", 32'(dbg_state), 32'(ST_INIT));
        check("rst_mem_read", 32'(mem_read), 0);
        check("rst_mem_write", 32'(mem_write), 0);
        check("rst_mem_refresh", 32'(mem_refresh), 0);
        check("rst_vid_valid", 32'(vid_valid), 0);
        check("rst_cpu_valid", 32'(cpu_valid), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_overrun", 32'(dbg_refresh_overrun), 0);
        reset = 1'b0;

        // Requests ignored while the controller is not enabled.
        vid_req = 1'b1; vid_addr = 23'h000100; mem_dout16 = 16'hBEEF;
        pulses = 0;
        repeat (20) begin
            step();
            if (mem_read || mem_write || mem_refresh || vid_ack) pulses++;
        end
        check("init_no_cmd", 32'(pulses), 0);
        check("init_state", 32'(dbg_state), 32'(ST_INIT));

        mem_enabled = 1'b1;
        step();
        check("enable_state", 32'(dbg_state), 32'(ST_READY));
        check("enable_no_read_yet", 32'(mem_read), 0);
        step();
        check("vid_issue_read", 32'(mem_read), 1);
        check("vid_issue_ack", 32'(vid_ack), 1);
        check("vid_issue_addr", 32'(mem_addr), 32'h100);
        check("vid_issue_state", 32'(dbg_state), 32'(ST_SLOT));
        vid_req = 1'b0;
        e0 = cyc;
        step();
        check("vid_read_one_cycle", 32'(mem_read), 0);
        repeat (4) step();
        check("vid_valid_not_early", 32'(cyc - e0 == 5 ? vid_valid : 1'bx), 0);
        step();
        check("vid_valid_at_lat", 32'(vid_valid), 1);
        check("vid_data", 32'(vid_data), 32'hBEEF);
        step();
        check("vid_valid_one_cycle", 32'(vid_valid), 0);

        // CPU write.
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 23'h000003; cpu_din = 8'h5A;
        step();
        check("wr_mem_write", 32'(mem_write), 1);
        check("wr_no_read", 32'(mem_read), 0);
        check("wr_ack", 32'(cpu_ack), 1);
        check("wr_addr", 32'(mem_addr), 32'h3);
        check("wr_din", 32'(mem_din8), 32'h5A);
        cpu_req = 1'b0;
        step();
        check("wr_one_cycle", 32'(mem_write), 0);
        pulses = 0;
        repeat (8) begin
            step();
            if (cpu_valid) pulses++;
        end
        check("wr_no_valid", 32'(pulses), 0);

        // CPU read, odd byte.
        mem_dout16 = 16'h12AB;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 23'h000001;
        step();
        check("rd_mem_read", 32'(mem_read), 1);
        check("rd_ack", 32'(cpu_ack), 1);
        check("rd_addr", 32'(mem_addr), 32'h1);
        cpu_req = 1'b0;
        repeat (5) step();
        check("rd_valid_not_early", 32'(cpu_valid), 0);
        step();
        check("rd_valid", 32'(cpu_valid), 1);
        check("rd_dout_hi", 32'(cpu_dout), 32'h12);
        check("rd_no_vid_valid", 32'(vid_valid), 0);

        // CPU read, even byte.
        mem_dout16 = 16'h34CD;
        cpu_req = 1'b1; cpu_addr = 23'h000002;
        step();
        check("rd2_ack", 32'(cpu_ack), 1);
        cpu_req = 1'b0;
        repeat (6) step();
        check("rd2_valid", 32'(cpu_valid), 1);
        check("rd2_dout_lo", 32'(cpu_dout), 32'hCD);

        // Both clients held: video twice, then the CPU, every 5 edges.
        vid_req = 1'b1; cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = '0; cpu_din = '0;
        rec_cli = '{0, 0, 0, 0, 0, 0};
        rec_cyc = '{0, 0, 0, 0, 0, 0};
        n = 0;
        bad = 0;
        start = cyc;
        for (int i = 0; i < 60 && n < 6; i++) begin
            step();
            if (vid_ack && cpu_ack) bad++;
            if (vid_ack || cpu_ack) begin
                rec_cli[n] = cpu_ack ? 2 : 1;
                rec_cyc[n] = cyc;
                n++;
            end
        end
        check("arb_grant_count", 32'(n), 6);
        check("arb_single_ack", 32'(bad), 0);
        check("arb_first_latency", 32'(rec_cyc[0] - start), 1);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("arb_order_%0d", k), 32'(rec_cli[k]), 32'(exp_cli[k]));
        end
        for (int k = 1; k < 6; k++) begin
            check($sformatf("arb_gap_%0d", k), 32'(rec_cyc[k] - rec_cyc[k-1]), 5);
        end
        vid_req = 1'b0; cpu_req = 1'b0;

        // Continuous video: refresh lands every 405 cycles without overrun.
        vid_req = 1'b1;
        ref_n = 0; last_ref = 0; bad = 0;
        repeat (2000) begin
            step();
            if (mem_refresh) begin
                if (mem_read || mem_write) bad++;
                if (ref_n > 0) check("refresh_gap", 32'(cyc - last_ref), 405);
                last_ref = cyc;
                ref_n++;
            end
        end
        check("refresh_count_ok", 32'(ref_n >= 4 && ref_n <= 5), 1);
        check("refresh_exclusive", 32'(bad), 0);
        check("refresh_no_overrun", 32'(dbg_refresh_overrun), 0);

        // Reset in the middle of a video read.
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (vid_ack) found = 1'b1;
        end
        check("mid_rst_ack_seen", 32'(found), 1);
        vid_req = 1'b0;
        repeat (2) step();
        #2 reset = 1'b1;
        #1;
        check("mid_rst_state", 32'(dbg_state), 32'(ST_INIT));
        check("mid_rst_read", 32'(mem_read), 0);
        step();
        reset = 1'b0;
        pulses = 0;
        repeat (12) begin
            step();
            if (vid_valid) pulses++;
        end
        check("mid_rst_no_valid", 32'(pulses), 0);
        check("mid_rst_overrun", 32'(dbg_refresh_overrun), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
